// File: rtl/uart_parity_gen.sv
// rtl/uart_parity_gen.sv - UART TX parity generator; serial self-checker built when UART_PAR_CHK_EN is defined
module uart_parity_gen #(
    parameter  int DATA_W = 8,
    localparam int LEN_W  = $clog2(DATA_W + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] P_DATA,
    input  logic [LEN_W-1:0]  DATA_LEN,
    input  logic              PAR_EN,
    input  logic [1:0]        PAR_MODE,
    input  logic              Data_Valid,
    input  logic              Busy,
    input  logic              ser_en,
    input  logic              ser_bit,
    output logic              par_bit,
    output logic              par_vld,
    output logic              chk_done,
    output logic              chk_err
);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DATA_W);

    logic              load;
    logic [LEN_W-1:0]  len_eff;
    logic [DATA_W-1:0] data_masked;
    logic              raw_xor;
    logic              par_d;
    logic              par_bit_q;
    logic              par_vld_q;

    assign load    = Data_Valid && !Busy;
    assign len_eff = (DATA_LEN == '0 || DATA_LEN > LEN_MAX) ? LEN_MAX : DATA_LEN;

    always_comb begin
        for (int i = 0; i < DATA_W; i++)
            data_masked[i] = P_DATA[i] && (LEN_W'(i) < len_eff);
    end

    assign raw_xor = ^data_masked;

    always_comb begin
        par_d = 1'b0;
        if (PAR_EN) begin
            case (PAR_MODE)
                2'b00:   par_d = raw_xor;
                2'b01:   par_d = !raw_xor;
                2'b10:   par_d = 1'b1;
                default: par_d = 1'b0;
            endcase
        end
    end

    // Parity is resolved at load time, so later input changes cannot leak into the frame.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_bit_q <= 1'b0;
            par_vld_q <= 1'b0;
        end else if (load) begin
            par_bit_q <= par_d;
            par_vld_q <= 1'b1;
        end
    end

    assign par_bit = par_bit_q;
    assign par_vld = par_vld_q;

`ifdef UART_PAR_CHK_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q;
    logic             acc_q, acc_d;
    logic             xor_q;
    logic             done_q, done_d;
    logic             err_q, err_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            acc_q   <= 1'b0;
            xor_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (load) begin
                len_q <= len_eff;
                xor_q <= raw_xor;
            end
        end
    end

    // A load always wins, which also aborts a frame still in CHECK without a done pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        err_d   = err_q;
        done_d  = 1'b0;
        if (load) begin
            state_d = CHECK;
            cnt_d   = '0;
            acc_d   = 1'b0;
            err_d   = 1'b0;
        end else if (state_q == CHECK && ser_en) begin
            acc_d = acc_q ^ ser_bit;
            if (cnt_q == len_q - LEN_W'(1)) begin
                state_d = DONE;
                done_d  = 1'b1;
                err_d   = (acc_q ^ ser_bit) != xor_q;
            end else begin
                cnt_d = cnt_q + LEN_W'(1);
            end
        end
    end

    assign chk_done = done_q;
    assign chk_err  = err_q;
`else
    logic unused_ser;

    assign unused_ser = ser_en ^ ser_bit;
    assign chk_done   = 1'b0;
    assign chk_err    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_parity_gen.sv
// tb/tb_uart_parity_gen.sv - table-driven, scoreboarded bench for uart_parity_gen
module tb_uart_parity_gen;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 4;
`ifdef UART_PAR_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic [DATA_W-1:0] P_DATA = '0;
    logic [LEN_W-1:0]  DATA_LEN = '0;
    logic              PAR_EN = 1'b0;
    logic [1:0]        PAR_MODE = 2'b00;
    logic              Data_Valid = 1'b0;
    logic              Busy = 1'b0;
    logic              ser_en = 1'b0;
    logic              ser_bit = 1'b0;
    logic              par_bit, par_vld, chk_done, chk_err;

    uart_parity_gen #(.DATA_W(DATA_W)) dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_LEN(DATA_LEN),
        .PAR_EN(PAR_EN), .PAR_MODE(PAR_MODE), .Data_Valid(Data_Valid), .Busy(Busy),
        .ser_en(ser_en), .ser_bit(ser_bit), .par_bit(par_bit), .par_vld(par_vld),
        .chk_done(chk_done), .chk_err(chk_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] data;
        logic [3:0] len;
        logic       en;
        logic [1:0] mode;
        logic       exp_par;
    } vec_t;

    logic sb_par[$];
    logic sb_err[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    logic cur_xor = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic ref_xor(input logic [7:0] d, input logic [3:0] len);
        int   l;
        logic x;
        l = (len == 0 || len > 8) ? 8 : int'(len);
        x = 1'b0;
        for (int i = 0; i < l; i++) x = x ^ d[i];
        return x;
    endfunction

    function automatic logic ref_par(input logic [7:0] d, input logic [3:0] len,
                                     input logic en, input logic [1:0] mode);
        if (!en) return 1'b0;
        case (mode)
            2'b00:   return ref_xor(d, len);
            2'b01:   return !ref_xor(d, len);
            2'b10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // A frame's expected chk_err is popped whenever the DUT raises chk_done.
    always @(negedge CLK) begin
        if (RST && chk_done) begin
            if (sb_err.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL chk_done_unexpected: got 1, expected 0");
            end else begin
                check("chk_err_at_done", chk_err, sb_err.pop_front());
            end
        end
    end

    task automatic do_load(input logic [7:0] d, input logic [3:0] len, input logic en,
                           input logic [1:0] mode, input logic exp_par, input string name);
        logic e;
        @(negedge CLK);
        P_DATA = d; DATA_LEN = len; PAR_EN = en; PAR_MODE = mode;
        Data_Valid = 1'b1; Busy = 1'b0;
        sb_par.push_back(exp_par);
        cur_xor = ref_xor(d, len);
        @(negedge CLK);
        Data_Valid = 1'b0;
        P_DATA = 8'($urandom); DATA_LEN = 4'($urandom); PAR_EN = 1'($urandom); PAR_MODE = 2'($urandom);
        if (sb_par.size() == 0) begin
            check({name, "_sb_empty"}, 1, 0);
        end else begin
            e = sb_par.pop_front();
            check({name, "_par_bit"}, par_bit, e);
            check({name, "_par_vld"}, par_vld, 1);
            @(negedge CLK);
            check({name, "_par_hold"}, par_bit, e);
        end
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n, input bit completes);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            ser_en = 1'b1; ser_bit = bits[i];
            acc = acc ^ bits[i];
            if (completes && i == n - 1) begin
                @(posedge CLK);
                #1;
                if (CHK) sb_err.push_back(acc != cur_xor);
            end
        end
        @(negedge CLK);
        ser_en = 1'b0; ser_bit = 1'b0;
    endtask

    task automatic expect_drained(input string name);
        @(negedge CLK);
        check(name, sb_err.size(), 0);
    endtask

    vec_t vecs[] = '{
        '{8'hA7, 4'd8,  1'b1, 2'b00, 1'b1},
        '{8'hA7, 4'd8,  1'b1, 2'b01, 1'b0},
        '{8'hA7, 4'd8,  1'b1, 2'b10, 1'b1},
        '{8'hA7, 4'd8,  1'b1, 2'b11, 1'b0},
        '{8'hE1, 4'd5,  1'b1, 2'b00, 1'b1},
        '{8'hE1, 4'd5,  1'b1, 2'b01, 1'b0},
        '{8'hFF, 4'd0,  1'b1, 2'b00, 1'b0},
        '{8'hFF, 4'd9,  1'b1, 2'b01, 1'b1},
        '{8'h01, 4'd8,  1'b0, 2'b01, 1'b0},
        '{8'h80, 4'd8,  1'b1, 2'b00, 1'b1},
        '{8'h80, 4'd7,  1'b1, 2'b00, 1'b0},
        '{8'h3C, 4'd1,  1'b1, 2'b00, 1'b0},
        '{8'h3C, 4'd1,  1'b1, 2'b01, 1'b1},
        '{8'h55, 4'd3,  1'b1, 2'b10, 1'b1},
        '{8'h55, 4'd3,  1'b0, 2'b10, 1'b0},
        '{8'h55, 4'd3,  1'b1, 2'b01, 1'b1},
        '{8'h7F, 4'd15, 1'b1, 2'b00, 1'b1}
    };

    initial begin
        logic [7:0] rd;
        logic [3:0] rl;
        logic       re;
        logic [1:0] rm;

        repeat (3) @(negedge CLK);
        RST = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            check("rst_par_bit", par_bit, 0);
            check("rst_par_vld", par_vld, 0);
            check("rst_chk_done", chk_done, 0);
            check("rst_chk_err", chk_err, 0);
        end

        send_bits(16'hFFFF, 4, 1'b0);
        expect_drained("idle_ser_en_ignored");
        check("idle_par_vld", par_vld, 0);

        for (int i = 0; i < vecs.size(); i++)
            do_load(vecs[i].data, vecs[i].len, vecs[i].en, vecs[i].mode, vecs[i].exp_par, $sformatf("vec%0d", i));

        for (int i = 0; i < 20; i++) begin
            rd = 8'($urandom); rl = 4'($urandom); re = 1'($urandom); rm = 2'($urandom);
            do_load(rd, rl, re, rm, ref_par(rd, rl, re, rm), $sformatf("rnd%0d", i));
        end

        do_load(8'hE1, 4'd5, 1'b1, 2'b00, 1'b1, "chk_good");
        send_bits(16'h0001, 5, 1'b1);
        expect_drained("chk_good_done");
        check("chk_good_err", chk_err, 0);

        do_load(8'hE1, 4'd5, 1'b1, 2'b00, 1'b1, "chk_bad");
        send_bits(16'h0005, 5, 1'b1);
        expect_drained("chk_bad_done");
        send_bits(16'hFFFF, 3, 1'b0);
        expect_drained("done_ser_en_ignored");
        check("chk_err_hold", chk_err, CHK);
        do_load(8'h00, 4'd8, 1'b1, 2'b00, 1'b0, "chk_err_clear");
        check("chk_err_cleared", chk_err, 0);

        do_load(8'hA7, 4'd8, 1'b1, 2'b00, 1'b1, "abort_first");
        send_bits(16'h00A7, 2, 1'b0);
        @(negedge CLK);
        P_DATA = 8'hFF; DATA_LEN = 4'd8; PAR_EN = 1'b1; PAR_MODE = 2'b00;
        Data_Valid = 1'b1; Busy = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0; Busy = 1'b0;
        check("busy_par_bit", par_bit, 1);
        check("busy_par_vld", par_vld, 1);
        send_bits(16'h0001, 1, 1'b0);
        do_load(8'h3C, 4'd8, 1'b1, 2'b00, 1'b0, "abort_second");
        send_bits(16'h003C, 8, 1'b1);
        expect_drained("abort_restart_done");
        check("abort_restart_err", chk_err, 0);

        do_load(8'h01, 4'd8, 1'b0, 2'b01, 1'b0, "par_en_off");
        send_bits(16'h0001, 3, 1'b0);
        @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        check("async_rst_par_bit", par_bit, 0);
        check("async_rst_par_vld", par_vld, 0);
        check("async_rst_chk_done", chk_done, 0);
        check("async_rst_chk_err", chk_err, 0);
        @(negedge CLK);
        RST = 1'b1;
        send_bits(16'hFFFF, 8, 1'b0);
        expect_drained("post_rst_no_done");
        check("post_rst_par_vld", par_vld, 0);

        check("sb_err_empty", sb_err.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_parity_gen.md
Name: uart_parity_gen

Overview:
- Parametrised parity generator for the UART TX path, with an optional serial self-checker.
- Captures a data word on an accepted load and latches a registered parity bit for the serializer.
- Supports runtime data length and four parity modes: even, odd, mark, space.
- When the checker is compiled in, it re-accumulates parity from the serializer's outgoing bit stream and flags any mismatch.

Parameters:
- DATA_W, 8, maximum data bits per frame (legal 1..16).
- LEN_W, $clog2(DATA_W+1), width of DATA_LEN (derived; do not override).

Ports:
- CLK  input  1  clock.
- RST  input  1  asynchronous, active-low reset.
- P_DATA  input  DATA_W  parallel data word; bit 0 is sent first.
- DATA_LEN  input  LEN_W  active data bits; 0 or >DATA_W is treated as DATA_W.
- PAR_EN  input  1  parity enable; 0 forces par_bit=0.
- PAR_MODE  input  2  00 even, 01 odd, 10 mark, 11 space.
- Data_Valid  input  1  new word offered.
- Busy  input  1  serializer busy; blocks loads.
- ser_en  input  1  serializer shifted one data bit this cycle.
- ser_bit  input  1  data bit on the line this cycle.
- par_bit  output  1  parity bit for the current frame.
- par_vld  output  1  par_bit valid for the current frame.
- chk_done  output  1  one-cycle pulse: all data bits observed.
- chk_err  output  1  sticky mismatch flag for the current frame.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counter 0, accumulator 0.
- Load condition: Data_Valid && !Busy, accepted in any state.
- On load:
  - Latch P_DATA with bits [DATA_W-1:len] masked to 0.
  - Latch len, PAR_EN and PAR_MODE; later input changes do not affect the frame.
- One cycle after load (one-cycle latency), par_vld=1 and par_bit is updated:
  - even: XOR of the masked word, so ones count including parity is even.
  - odd: inverse of even.
  - mark: 1.
  - space: 0.
  - PAR_EN=0: par_bit=0.
- par_bit and par_vld hold until the next load. par_vld never drops except on reset.
- Data_Valid with Busy=1: ignored; no state change.
- FSM states: IDLE, CHECK, DONE.
  - IDLE/DONE --load--> CHECK. Counter and accumulator are cleared, chk_err is cleared.
  - CHECK: each cycle with ser_en=1, acc ^= ser_bit and cnt++.
  - CHECK --(ser_en && cnt==len-1)--> DONE. chk_done pulses in the cycle DONE is entered.
  - At that edge, chk_err <= (acc ^ ser_bit) != latched raw XOR of the masked word. The comparison is independent of mode and PAR_EN.
  - DONE: chk_err held; ser_en is ignored.
  - Load while in CHECK: the current check is aborted with no chk_done, and a new frame starts per the load rules.
- ser_en outside CHECK: ignored.
- Counter never exceeds len-1; no wrap-around.
- Reset asserted mid-frame: immediate return to reset values, with no chk_done.

Optional Feature:
- Macro UART_PAR_CHK_EN.
  - Defined: CHECK/DONE FSM, counter and accumulator are built as described.
  - Undefined: FSM, counter and accumulator are removed; chk_done and chk_err are tied 0; ser_en and ser_bit are unused. par_bit/par_vld behaviour is unchanged.

Test Plan:
- Reset release, no stimulus -> par_bit=0, par_vld=0, chk_done=0, chk_err=0 for 10 cycles.
- DATA_W=8, DATA_LEN=8, P_DATA=8'hA7, PAR_MODE=00, load -> next cycle par_vld=1, par_bit=1. Repeat with PAR_MODE=01 -> par_bit=0; 10 -> 1; 11 -> 0.
- DATA_LEN=5, P_DATA=8'hE1, mode even -> masked 5'h01, par_bit=1. Then 5 ser_en pulses with bits 1,0,0,0,0 -> chk_done pulses on the 5th, chk_err=0.
- Same frame, but the serializer drives the 3rd bit as 1 -> chk_done pulses, chk_err=1, and chk_err holds until the next load.
- Data_Valid=1 with Busy=1 and P_DATA=8'hFF -> par_bit/par_vld unchanged. Then a load mid-CHECK after 3 ser_en pulses -> no chk_done for the aborted frame, counter restarts, and the new frame checks correctly.
- PAR_EN=0, P_DATA=8'h01, mode odd -> par_bit=0. Assert RST mid-CHECK -> all outputs 0 asynchronously.
